// File: rtl/signed_bcd_pkg_v.sv
// Shared types and constants for the signed binary-to-BCD conversion stage.
package signed_bcd_pkg_v;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_add3_v.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_v
  import signed_bcd_pkg_v::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= BCD_W'(5)) adj_c = digit + BCD_W'(3);
  end

endmodule

// File: rtl/signed_bcd_conv_v.sv
// Signed two's-complement to sign + 3-digit BCD converter (multi-cycle double-dabble).
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits and suppress the sign of zero.
module signed_bcd_conv_v
  import signed_bcd_pkg_v::*;
#(
  parameter int unsigned W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [W-1:0]       i_fu,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sign,
  output logic [BCD_W-1:0]   o_hund,
  output logic [BCD_W-1:0]   o_tens,
  output logic [BCD_W-1:0]   o_ones
);

  localparam int unsigned SCR_W = BCD_W * NUM_DIGITS;
  localparam int unsigned CNT_W = 4;

  state_t             state;
  state_t             state_nxt;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [W-1:0]       mag;
  logic               sign_r;
  logic [CNT_W-1:0]   count;
  logic               last_shift_c;
  logic [BCD_W-1:0]   hund_c;
  logic [BCD_W-1:0]   tens_c;
  logic [BCD_W-1:0]   ones_c;

  assign last_shift_c = (count == CNT_W'(W - 1));
  assign hund_c = scratch[2*BCD_W +: BCD_W];
  assign tens_c = scratch[1*BCD_W +: BCD_W];
  assign ones_c = scratch[0*BCD_W +: BCD_W];

  // Per-digit add-3 correction applied before every shift
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3_v u_add3 (
      .digit (scratch[g*BCD_W +: BCD_W]),
      .adj_c (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = SHIFT;
      SHIFT:   if (last_shift_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      scratch <= '0;
      mag     <= '0;
      sign_r  <= 1'b0;
      count   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sign  <= 1'b0;
      o_hund  <= '0;
      o_tens  <= '0;
      o_ones  <= '0;
    end else begin
      state  <= state_nxt;
      // Busy stays up through the cycle in which o_done is presented
      o_busy <= (state != IDLE) || i_start;
      o_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (i_start) begin
            sign_r  <= i_fu[W-1];
            mag     <= i_fu[W-1] ? W'(-i_fu) : i_fu;
            scratch <= '0;
            count   <= '0;
          end
        end
        SHIFT: begin
          {scratch, mag} <= {scratch_adj, mag} << 1;
          count          <= count + CNT_W'(1);
        end
        DONE: begin
          o_ones <= ones_c;
`ifdef LEADING_ZERO_BLANK_EN
          o_hund <= (hund_c == '0) ? BCD_BLANK : hund_c;
          o_tens <= ((hund_c == '0) && (tens_c == '0)) ? BCD_BLANK : tens_c;
          o_sign <= (scratch == '0) ? 1'b0 : sign_r;
`else
          o_hund <= hund_c;
          o_tens <= tens_c;
          o_sign <= sign_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_conv_v.sv
// Directed bench for signed_bcd_conv_v: vector table, corner sequences, full sweep.
module tb_signed_bcd_conv_v;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [8:0] i_fu;
  logic       o_busy;
  logic       o_done;
  logic       o_sign;
  logic [3:0] o_hund;
  logic [3:0] o_tens;
  logic [3:0] o_ones;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  int n_starts = 0;

  signed_bcd_conv_v #(.W(9)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_fu    (i_fu),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sign  (o_sign),
    .o_hund  (o_hund),
    .o_tens  (o_tens),
    .o_ones  (o_ones)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_done) n_done++;

  typedef struct {
    logic [8:0] fu;
    logic       sign;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Raw expected digits adjusted for the optional blanking build
  function automatic logic [12:0] fmt(input logic s, input logic [3:0] h, input logic [3:0] t,
                                      input logic [3:0] o);
    logic [12:0] r;
    r = {s, h, t, o};
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 4'd0) r[11:8] = 4'hF;
    if (h == 4'd0 && t == 4'd0) r[7:4] = 4'hF;
    if (h == 4'd0 && t == 4'd0 && o == 4'd0) r[12] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [12:0] model(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return fmt(v < 0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10));
  endfunction

  // Call at a negedge; returns at the negedge where o_done is seen (or after a bound)
  task automatic run_conv(input logic [8:0] fu, output logic [12:0] res,
                          output int lat, output int busy_n);
    i_fu = fu;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n_starts++;
    lat = 0;
    busy_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      lat++;
      if (o_busy) busy_n++;
      if (o_done) break;
    end
    chk("done_seen", 32'(o_done), 32'd1);
    res = {o_sign, o_hund, o_tens, o_ones};
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_done) break;
    end
    chk("done_seen", 32'(o_done), 32'd1);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [12:0] res;
    int          lat;
    int          busy_n;
    int          done_before;

    vecs[0] = '{9'd195, 1'b0, 4'd1, 4'd9, 4'd5};
    vecs[1] = '{9'h1D3, 1'b1, 4'd0, 4'd4, 4'd5};
    vecs[2] = '{9'h100, 1'b1, 4'd2, 4'd5, 4'd6};
    vecs[3] = '{9'd0,   1'b0, 4'd0, 4'd0, 4'd0};
    vecs[4] = '{9'h1FF, 1'b1, 4'd0, 4'd0, 4'd1};
    vecs[5] = '{9'd255, 1'b0, 4'd2, 4'd5, 4'd5};
    vecs[6] = '{9'd100, 1'b0, 4'd1, 4'd0, 4'd0};
    vecs[7] = '{9'h19C, 1'b1, 4'd1, 4'd0, 4'd0};

    i_rst = 1'b1;
    i_start = 1'b0;
    i_fu = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_out", 32'({o_sign, o_hund, o_tens, o_ones}), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    foreach (vecs[i]) begin
      run_conv(vecs[i].fu, res, lat, busy_n);
      chk($sformatf("vec%0d_out", i), 32'(res),
          32'(fmt(vecs[i].sign, vecs[i].hund, vecs[i].tens, vecs[i].ones)));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd11);
      chk($sformatf("vec%0d_busy", i), 32'(busy_n), 32'd11);
      @(negedge i_clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(o_done), 32'd0);
    end

    // Start during busy is ignored; i_fu change after capture has no effect
    i_fu = 9'd195;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n_starts++;
    repeat (4) @(negedge i_clk);
    i_fu = 9'd7;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done();
    chk("ignored_start_out", 32'({o_sign, o_hund, o_tens, o_ones}), 32'(fmt(0, 1, 9, 5)));

    // Fresh start right after done; outputs hold old result until new DONE
    i_fu = 9'd7;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n_starts++;
    repeat (5) @(negedge i_clk);
    chk("hold_busy", 32'(o_busy), 32'd1);
    chk("hold_out", 32'({o_sign, o_hund, o_tens, o_ones}), 32'(fmt(0, 1, 9, 5)));
    wait_done();
    chk("b2b_out", 32'({o_sign, o_hund, o_tens, o_ones}), 32'(fmt(0, 0, 0, 7)));
    @(negedge i_clk);

    // Reset in the middle of SHIFT aborts without a done pulse
    i_fu = 9'd195;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    done_before = n_done;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_out", 32'({o_sign, o_hund, o_tens, o_ones}), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (15) @(negedge i_clk);
    chk("midrst_no_done", 32'(n_done - done_before), 32'd0);
    run_conv(9'h1FF, res, lat, busy_n);
    chk("after_rst_out", 32'(res), 32'(fmt(1, 0, 0, 1)));

    // Full sweep with back-to-back starts
    for (int v = -256; v <= 255; v++) begin
      run_conv(9'(v), res, lat, busy_n);
      chk($sformatf("sweep_%0d", v), 32'(res), 32'(model(v)));
    end

    @(negedge i_clk);
    chk("done_count", 32'(n_done), 32'(n_starts));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
